// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch/execute sequencer driving the PC block, with a small return-address stack
// for call/ret and a saturating retired-instruction counter.
module pc_seq_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cur_instr_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [2:0]        br_op,
    input  logic              br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              pc_enable,
    output logic              pc_reset,
    output logic [1:0]        pc_jump_mode,
    output logic              pc_cond_skip,
    output logic [ADDR_W-1:0] pc_jump_addr,
    output logic              busy,
    output logic              done,
    output logic              ras_overflow,
    output logic              ras_underflow,
    output logic [15:0]       instr_count
);
    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int SP_W  = IDX_W + 1;
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, EXEC, DONE} state_t;
    state_t state, state_n;
    logic [2:0]        op_q;
    logic              cond_q;
    logic [ADDR_W-1:0] target_q, ret_q;
    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [SP_W-1:0]   sp, sp_m1;
    logic              full, empty, ovf, unf, stop, push, pop;
    assign sp_m1 = sp - 1'b1;
    assign full  = sp == SP_W'(RAS_DEPTH);
    assign empty = sp == '0;
    assign ovf   = op_q == 3'd4 && full;
    assign unf   = op_q == 3'd5 && empty;
    assign stop  = ovf || unf || op_q == 3'd6;
    always_comb begin
        state_n      = state;
        imem_req     = 1'b0;
        pc_enable    = 1'b0;
        pc_reset     = 1'b0;
        pc_jump_mode = 2'b00;
        pc_cond_skip = 1'b0;
        pc_jump_addr = '0;
        busy         = 1'b0;
        done         = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE:  state_n = start ? CLEAR : IDLE;
            CLEAR: begin
                busy     = 1'b1;
                pc_reset = 1'b1;
                state_n  = FETCH;
            end
            FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                state_n  = imem_ack ? EXEC : FETCH;
            end
            EXEC: begin
                busy         = 1'b1;
                pc_enable    = !stop;
                state_n      = stop ? DONE : FETCH;
                push         = op_q == 3'd4 && !full;
                pop          = op_q == 3'd5 && !empty;
                pc_jump_mode = op_q == 3'd1 ? 2'b01 :
                               op_q == 3'd2 ? 2'b10 :
                               (op_q == 3'd3 || push || pop) ? 2'b11 : 2'b00;
                pc_cond_skip = op_q == 3'd1 && cond_q;
                pc_jump_addr = pop ? ras[sp_m1[IDX_W-1:0]] :
                               (op_q == 3'd3 || push) ? target_q : '0;
            end
            DONE: begin
                done    = 1'b1;
                state_n = start ? CLEAR : DONE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= '0;
            cond_q        <= 1'b0;
            target_q      <= '0;
            ret_q         <= '0;
            sp            <= '0;
            instr_count   <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
        end else begin
            state <= state_n;
            if (state == FETCH && imem_ack) begin
                op_q     <= br_op;
                cond_q   <= br_cond;
                target_q <= br_target;
                ret_q    <= cur_instr_addr + ADDR_W'(1);
            end
            if (state == CLEAR) begin
                sp            <= '0;
                instr_count   <= '0;
                ras_overflow  <= 1'b0;
                ras_underflow <= 1'b0;
            end
            if (push) begin
                ras[sp[IDX_W-1:0]] <= ret_q;
                sp                 <= sp + 1'b1;
            end
            if (pop) sp <= sp_m1;
            // stack faults end the run without retiring the offending instruction
            if (state == EXEC) begin
                ras_overflow  <= ras_overflow | ovf;
                ras_underflow <= ras_underflow | unf;
                if (!(ovf || unf) && instr_count != 16'hFFFF) instr_count <= instr_count + 1'b1;
            end
        end
    end
endmodule
